// File: rtl/arbitro_roteador_if.sv
// Request/grant bundle between the four sources, the arbiter and the 4:1 router.
// master = arbiter side, slave = sources/router side.
interface arbitro_roteador_if #(
   parameter int SEL_BITS = 2
);
   logic [3:0]          REQ;
   logic [SEL_BITS-1:0] SEL;
   logic [3:0]          GNT;
   logic                VALIDO;
   logic [3:0]          ACK;

   modport master (
      input  REQ,
      output SEL,
      output GNT,
      output VALIDO,
      output ACK
   );

   modport slave (
      output REQ,
      input  SEL,
      input  GNT,
      input  VALIDO,
      input  ACK
   );
endinterface

// File: rtl/arbitro_roteador.sv
// Round-robin arbiter driving the 4:1 router SEL; each grant is held HOLD_CYCLES cycles.
// Define ARB_PRIORIDADE_FIXA_EN for fixed priority A > B > C > D instead of round-robin.
module arbitro_roteador #(
   parameter int SEL_BITS    = 2,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                clock,
   input  logic                reset,
   arbitro_roteador_if.master  bus
);

   typedef enum logic {
      OCIOSO,
      CONCEDE
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);

   state_t              state;
   logic [SEL_BITS-1:0] sel;
   logic [SEL_BITS-1:0] ptr;
   logic [3:0]          gnt;
   logic                valido;
   logic [3:0]          cnt;

   logic [SEL_BITS-1:0] scan_base;
   logic [SEL_BITS-1:0] cand;
   logic [SEL_BITS-1:0] win;
   logic                found;
   logic                fim;
   logic                start;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      scan_base = '0;
      cand      = '0;
      win       = '0;
      found     = 1'b0;
`ifndef ARB_PRIORIDADE_FIXA_EN
      // At grant end the new pointer (idx+1) is not registered yet, so derive it here.
      scan_base = (state == CONCEDE) ? sel + 1'b1 : ptr;
`endif
      // Scan from farthest to nearest so the nearest set bit wins last.
      for (int i = 3; i >= 0; i--) begin
         cand = scan_base + SEL_BITS'(i);
         if (bus.REQ[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Grant ends on its last cycle or when the granted source withdraws early.
   assign fim   = (state == CONCEDE) && ((cnt == 4'd0) || !bus.REQ[sel]);
   assign start = found && ((state == OCIOSO) || fim);

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= OCIOSO;
         sel    <= '0;
         ptr    <= '0;
         gnt    <= '0;
         valido <= 1'b0;
         cnt    <= '0;
      end else begin
`ifndef ARB_PRIORIDADE_FIXA_EN
         if (fim) ptr <= sel + 1'b1;
`endif
         if (start) begin
            state  <= CONCEDE;
            sel    <= win;
            gnt    <= 4'(1) << win;
            valido <= 1'b1;
            cnt    <= CNT_LOAD;
         end else if (fim) begin
            state  <= OCIOSO;
            gnt    <= '0;
            valido <= 1'b0;
            cnt    <= '0;
         end else if (state == CONCEDE) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   assign bus.SEL    = sel;
   assign bus.GNT    = gnt;
   assign bus.VALIDO = valido;
   assign bus.ACK    = ((state == CONCEDE) && (cnt == 4'd0)) ? gnt : 4'b0000;

endmodule

// File: tb/tb_arbitro_roteador.sv
// Directed self-checking bench for arbitro_roteador (HOLD_CYCLES=2).
// Observed vector = {SEL, GNT, VALIDO, ACK}, sampled on the falling edge.
module tb_arbitro_roteador;

   logic clock;
   logic reset;
   int   n_vec;
   int   n_err;

   arbitro_roteador_if #(.SEL_BITS(2)) bus ();

   arbitro_roteador #(
      .SEL_BITS    (2),
      .HOLD_CYCLES (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [10:0] vec(input logic [1:0] s, input logic [3:0] g,
                                       input logic v, input logic [3:0] a);
      return {s, g, v, a};
   endfunction

   task automatic do_reset();
      @(negedge clock);
      #2 reset = 1'b1;
      bus.REQ = 4'b0000;
      #2 reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] obs;
      #2;
      obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
      n_vec++;
      if (obs !== vec(2'd0, 4'b0000, 1'b0, 4'b0000)) begin
         n_err++;
         $display("FAIL reset_hold: got %b want %b", obs, vec(2'd0, 4'b0000, 1'b0, 4'b0000));
      end
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
         n_vec++;
         if (obs !== vec(2'd0, 4'b0000, 1'b0, 4'b0000)) begin
            n_err++;
            $display("FAIL reset_idle c%0d: got %b want %b", k, obs, vec(2'd0, 4'b0000, 1'b0, 4'b0000));
         end
      end
   endtask

   task automatic test_single();
      logic [10:0] obs;
      logic [10:0] exp_v [4];
      exp_v[0] = vec(2'd2, 4'b0100, 1'b1, 4'b0000);
      exp_v[1] = vec(2'd2, 4'b0100, 1'b1, 4'b0100);
      exp_v[2] = vec(2'd2, 4'b0100, 1'b1, 4'b0000);
      exp_v[3] = vec(2'd2, 4'b0100, 1'b1, 4'b0100);
      do_reset();
      @(negedge clock);
      bus.REQ = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         // Drop the request just after the edge that opens the regrant's last cycle.
         if (k == 3) begin
            @(posedge clock);
            #1 bus.REQ = 4'b0000;
         end
         @(negedge clock);
         obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
         n_vec++;
         if (obs !== exp_v[k]) begin
            n_err++;
            $display("FAIL single c%0d: got %b want %b", k, obs, exp_v[k]);
         end
      end
      @(negedge clock);
      obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
      n_vec++;
      if (obs !== vec(2'd2, 4'b0000, 1'b0, 4'b0000)) begin
         n_err++;
         $display("FAIL single_idle: got %b want %b", obs, vec(2'd2, 4'b0000, 1'b0, 4'b0000));
      end
   endtask

   task automatic test_round_robin();
      logic [10:0] obs;
      logic [10:0] exp;
      logic [1:0]  idx;
      do_reset();
      @(negedge clock);
      bus.REQ = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
`ifdef ARB_PRIORIDADE_FIXA_EN
         idx = 2'd0;
`else
         idx = 2'((k / 2) % 4);
`endif
         exp = vec(idx, 4'(1) << idx, 1'b1, (k % 2 == 1) ? 4'(1) << idx : 4'b0000);
         obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL round_robin c%0d: got %b want %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_abort();
      logic [10:0] obs;
      logic [10:0] exp_v [3];
      exp_v[0] = vec(2'd1, 4'b0010, 1'b1, 4'b0000);
      exp_v[1] = vec(2'd2, 4'b0100, 1'b1, 4'b0000);
      exp_v[2] = vec(2'd2, 4'b0100, 1'b1, 4'b0100);
      do_reset();
      @(negedge clock);
      bus.REQ = 4'b0110;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
         n_vec++;
         if (obs !== exp_v[k]) begin
            n_err++;
            $display("FAIL abort c%0d: got %b want %b", k, obs, exp_v[k]);
         end
         if (k == 0) bus.REQ = 4'b0100;
      end
   endtask

   task automatic test_reset_mid_grant();
      logic [10:0] obs;
      logic [10:0] exp_v [3];
      exp_v[0] = vec(2'd3, 4'b1000, 1'b1, 4'b0000);
      exp_v[1] = vec(2'd3, 4'b1000, 1'b1, 4'b0000);
      exp_v[2] = vec(2'd3, 4'b1000, 1'b1, 4'b1000);
      do_reset();
      @(negedge clock);
      bus.REQ = 4'b1000;
      @(negedge clock);
      obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
      n_vec++;
      if (obs !== exp_v[0]) begin
         n_err++;
         $display("FAIL rst_mid_pre: got %b want %b", obs, exp_v[0]);
      end
      #2 reset = 1'b1;
      #1;
      obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
      n_vec++;
      if (obs !== vec(2'd0, 4'b0000, 1'b0, 4'b0000)) begin
         n_err++;
         $display("FAIL rst_mid_async: got %b want %b", obs, vec(2'd0, 4'b0000, 1'b0, 4'b0000));
      end
      @(negedge clock);
      obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
      n_vec++;
      if (obs !== vec(2'd0, 4'b0000, 1'b0, 4'b0000)) begin
         n_err++;
         $display("FAIL rst_mid_held: got %b want %b", obs, vec(2'd0, 4'b0000, 1'b0, 4'b0000));
      end
      reset = 1'b0;
      for (int k = 1; k < 3; k++) begin
         @(negedge clock);
         obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
         n_vec++;
         if (obs !== exp_v[k]) begin
            n_err++;
            $display("FAIL rst_mid_regrant c%0d: got %b want %b", k, obs, exp_v[k]);
         end
      end
   endtask

   task automatic test_prioridade();
      logic [10:0] obs;
      logic [10:0] exp;
      logic [1:0]  idx;
      do_reset();
      @(negedge clock);
      bus.REQ = 4'b0011;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
`ifdef ARB_PRIORIDADE_FIXA_EN
         idx = 2'd0;
`else
         idx = 2'((k / 2) % 2);
`endif
         exp = vec(idx, 4'(1) << idx, 1'b1, (k % 2 == 1) ? 4'(1) << idx : 4'b0000);
         obs = {bus.SEL, bus.GNT, bus.VALIDO, bus.ACK};
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL prioridade c%0d: got %b want %b", k, obs, exp);
         end
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b1;
      bus.REQ = 4'b0000;
      test_reset();
      test_single();
      test_round_robin();
      test_abort();
      test_reset_mid_grant();
      test_prioridade();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/arbitro_roteador.md
Name: arbitro_roteador

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 data router and drives its SEL input.
- Four sources (A, B, C, D) raise requests. The arbiter grants one source at a time for a fixed number of cycles and drives SEL with that source's index.
- While the grant is valid, the router's 4-bit output carries the selected source.
- A one-cycle ACK tells the granted source that its transfer completed.

Parameters:
- SEL_BITS, 2, width of SEL; fixed at 2 for four sources.
- HOLD_CYCLES, 2, number of cycles each grant is held; legal values 1..15.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- REQ  input  4  request lines; bit0 = A, bit1 = B, bit2 = C, bit3 = D.
- SEL  output  SEL_BITS  index of the granted source; connects to the router's SEL.
- GNT  output  4  one-hot grant, registered; all zero when idle.
- VALIDO  output  1  high while a grant is active; router output is valid.
- ACK  output  4  one-hot completion pulse; high only in the last cycle of a full grant.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- All outputs are registered or decoded only from registered state. There is no combinational path from REQ to any output.
- Reset values: state OCIOSO, SEL=0, GNT=0, VALIDO=0, ACK=0, round-robin pointer PTR=0, hold counter CNT=0.
- Reset asserted mid-grant: outputs go to reset values immediately. No ACK is issued.
- State OCIOSO:
  - At a rising edge with REQ!=0, pick the first set bit scanning PTR, PTR+1, ... (mod 4).
  - Go to CONCEDE and load: SEL=idx, GNT=1<<idx, VALIDO=1, CNT=HOLD_CYCLES-1.
  - Latency: REQ sampled at edge n, so GNT/VALIDO are high in the cycle after edge n.
- State CONCEDE, normal operation:
  - CNT decrements each edge.
  - ACK[idx]=1 while CNT==0, i.e. the last grant cycle.
  - The grant lasts exactly HOLD_CYCLES cycles.
- End of grant (edge where CNT==0):
  - Set PTR=idx+1 mod 4.
  - Re-arbitrate in the same edge using the new PTR. The just-served source therefore has lowest priority.
  - If any REQ is set, start the new grant with no idle gap (back-to-back).
  - Otherwise go to OCIOSO with VALIDO=0, GNT=0. SEL holds its last value.
- Abort: REQ[idx]=0 sampled at an edge while CNT!=0.
  - The grant ends at that edge with no ACK.
  - PTR advances to idx+1 mod 4 and re-arbitration happens as at end of grant.
- REQ[idx] dropping during the final cycle (CNT==0): ACK is still issued, because it is state-decoded.
- Simultaneous requests: exactly one grant. GNT is always one-hot or zero. SEL always equals the encoded GNT whenever VALIDO=1.
- Only one source requesting continuously: it is re-granted back-to-back. ACK pulses every HOLD_CYCLES cycles.
- Wrap-around: idx=3 sets PTR=0.
- CNT width is 4 bits.
- HOLD_CYCLES=1: every grant cycle is also its ACK cycle, and abort cannot occur.

Optional Feature:
- Macro: ARB_PRIORIDADE_FIXA_EN.
- Defined: fixed priority A > B > C > D. PTR is ignored and never updated; the lowest set REQ bit always wins. A constantly requesting A starves the others. All other behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then idle: reset=1 mid-cycle, REQ=0000 -> SEL=0, GNT=0000, VALIDO=0, ACK=0000 immediately and after release.
- Single request: REQ=0100 at edge n, HOLD_CYCLES=2 -> GNT=0100 and SEL=2 in cycles n+1 and n+2; ACK=0100 only in n+2; back-to-back regrant from n+3 if REQ is held.
- Round robin: REQ=1111 held -> grant order A, B, C, D, A; SEL sequence 0,1,2,3,0, each held 2 cycles, no idle cycle between grants.
- Abort: B granted, REQ[1] dropped during first grant cycle -> grant ends at the next edge, no ACK; next grant goes to C if REQ[2]=1.
- Async reset mid-grant: reset pulse during D grant with CNT=1 -> outputs zero immediately, no ACK; after release with REQ=1000, A is not present so D is granted again, and PTR=0 scanning reaches D.
- ARB_PRIORIDADE_FIXA_EN defined, REQ=0011 held -> GNT=0001 every grant; B never granted.
